pipeline_hazard_ctrl: RTL and testbench

//  Central hazard unit for the 5-stage RV32IM pipeline: load-use stall, EX operand forwarding select,

---
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard unit: load-use stall, EX forwarding, MUL/DIV hold, dmem wait stall
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_rs1_id,
  input  logic [REG_ADDR_W-1:0] i_rs2_id,
  input  logic [REG_ADDR_W-1:0] i_rs1_ex,
  input  logic [REG_ADDR_W-1:0] i_rs2_ex,
  input  logic [REG_ADDR_W-1:0] i_rd_ex,
  input  logic                  i_regwrite_ex,
  input  logic                  i_load_ex,
  input  logic                  i_muldiv_ex,
  input  logic [REG_ADDR_W-1:0] i_rd_mem,
  input  logic                  i_regwrite_mem,
  input  logic                  i_load_mem,
  input  logic                  i_mem_access,
  input  logic                  i_mem_ready,
  input  logic [REG_ADDR_W-1:0] i_rd_wb,
  input  logic                  i_regwrite_wb,
  output logic                  o_stall_if,
  output logic                  o_stall_id,
  output logic                  o_stall_ex,
  output logic                  o_stall_mem,
  output logic                  o_bubble_ex,
  output logic                  o_bubble_mem,
  output logic                  o_bubble_wb,
  output logic [1:0]            o_fwd_rs1_sel,
  output logic [1:0]            o_fwd_rs2_sel,
`ifdef HAZARD_STALL_CNT_EN
  output logic [31:0]           o_stall_cycles,
`endif
  output logic                  o_muldiv_busy
);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_MULDIV = 1'b1
  } state_t;

  localparam logic        MD_EN      = (MULDIV_LAT >= 2) ? 1'b1 : 1'b0;
  localparam int unsigned CNT_INIT_I = (MULDIV_LAT >= 2) ? (MULDIV_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_INIT_I[CNT_W-1:0];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_mem_wait;
  logic w_load_use;
  logic w_rs1_mem_hit;
  logic w_rs2_mem_hit;
  logic w_rs1_wb_hit;
  logic w_rs2_wb_hit;

  assign w_mem_wait = i_mem_access & ~i_mem_ready;

  // x0 is hardwired zero, so a write to it never creates a dependency.
  assign w_rs1_mem_hit = i_regwrite_mem & ~i_load_mem & (i_rd_mem != '0) & (i_rs1_ex == i_rd_mem);
  assign w_rs2_mem_hit = i_regwrite_mem & ~i_load_mem & (i_rd_mem != '0) & (i_rs2_ex == i_rd_mem);
  assign w_rs1_wb_hit  = i_regwrite_wb & (i_rd_wb != '0) & (i_rs1_ex == i_rd_wb);
  assign w_rs2_wb_hit  = i_regwrite_wb & (i_rd_wb != '0) & (i_rs2_ex == i_rd_wb);

  assign w_load_use = i_load_ex & i_regwrite_ex & (i_rd_ex != '0) &
                      ((i_rd_ex == i_rs1_id) | (i_rd_ex == i_rs2_id));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else if (!w_mem_wait) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_stall_ex    = 1'b0;
    o_stall_mem   = 1'b0;
    o_bubble_ex   = 1'b0;
    o_bubble_mem  = 1'b0;
    o_bubble_wb   = 1'b0;
    o_fwd_rs1_sel = 2'b00;
    o_fwd_rs2_sel = 2'b00;
    o_muldiv_busy = 1'b0;

    // Outputs are forced quiet while reset is held, independent of inputs.
    if (i_reset) begin
      o_muldiv_busy = (r_state == S_MULDIV);

      if (w_rs1_mem_hit)     o_fwd_rs1_sel = 2'b01;
      else if (w_rs1_wb_hit) o_fwd_rs1_sel = 2'b10;
      if (w_rs2_mem_hit)     o_fwd_rs2_sel = 2'b01;
      else if (w_rs2_wb_hit) o_fwd_rs2_sel = 2'b10;

      if (w_mem_wait) begin
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_stall_ex  = 1'b1;
        o_stall_mem = 1'b1;
        o_bubble_wb = 1'b1;
      end else begin
        unique case (r_state)
          S_RUN: begin
            if (i_muldiv_ex && MD_EN) begin
              o_stall_if   = 1'b1;
              o_stall_id   = 1'b1;
              o_stall_ex   = 1'b1;
              o_bubble_mem = 1'b1;
              w_state_nxt  = S_MULDIV;
              w_cnt_nxt    = CNT_INIT;
            end else if (w_load_use) begin
              o_stall_if  = 1'b1;
              o_stall_id  = 1'b1;
              o_bubble_ex = 1'b1;
            end
          end
          S_MULDIV: begin
            if (r_cnt != '0) begin
              o_stall_if   = 1'b1;
              o_stall_id   = 1'b1;
              o_stall_ex   = 1'b1;
              o_bubble_mem = 1'b1;
              w_cnt_nxt    = r_cnt - CNT_W'(1);
            end else begin
              // Final cycle: the op leaves EX; its still-high muldiv_ex must not retrigger.
              w_state_nxt = S_RUN;
            end
          end
          default: w_state_nxt = S_RUN;
        endcase
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cycles <= '0;
    end else if (o_stall_if) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int AW  = 5;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic regwrite_ex, load_ex, muldiv_ex, regwrite_mem, load_mem, mem_access, mem_ready, regwrite_wb;
  logic stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb, muldiv_busy;
  logic [1:0] fwd1, fwd2;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MULDIV_LAT(LAT), .CNT_W(3)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_rs1_id(rs1_id), .i_rs2_id(rs2_id), .i_rs1_ex(rs1_ex), .i_rs2_ex(rs2_ex),
    .i_rd_ex(rd_ex), .i_regwrite_ex(regwrite_ex), .i_load_ex(load_ex), .i_muldiv_ex(muldiv_ex),
    .i_rd_mem(rd_mem), .i_regwrite_mem(regwrite_mem), .i_load_mem(load_mem),
    .i_mem_access(mem_access), .i_mem_ready(mem_ready),
    .i_rd_wb(rd_wb), .i_regwrite_wb(regwrite_wb),
    .o_stall_if(stall_if), .o_stall_id(stall_id), .o_stall_ex(stall_ex), .o_stall_mem(stall_mem),
    .o_bubble_ex(bubble_ex), .o_bubble_mem(bubble_mem), .o_bubble_wb(bubble_wb),
    .o_fwd_rs1_sel(fwd1), .o_fwd_rs2_sel(fwd2),
`ifdef HAZARD_STALL_CNT_EN
    .o_stall_cycles(stall_cycles),
`endif
    .o_muldiv_busy(muldiv_busy)
  );

  // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb, fwd1, fwd2, busy}
  wire [11:0] dut_v = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb,
                       fwd1, fwd2, muldiv_busy};

  typedef struct {
    string         name;
    logic [AW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic          rw_ex, ld_ex, rw_mem, ld_mem, acc, rdy, rw_wb;
    logic [11:0]   exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    regwrite_ex = 0; load_ex = 0; muldiv_ex = 0; regwrite_mem = 0; load_mem = 0;
    mem_access = 0; mem_ready = 1; regwrite_wb = 0;
  endtask

  function automatic vec_t mkv(string n, int r1i, int r2i, int r1e, int r2e, int rde, int rwe, int lde,
                               int rdm, int rwm, int ldm, int acc, int rdy, int rdw, int rww, logic [11:0] e);
    vec_t v;
    v.name = n; v.rs1_id = AW'(r1i); v.rs2_id = AW'(r2i); v.rs1_ex = AW'(r1e); v.rs2_ex = AW'(r2e);
    v.rd_ex = AW'(rde); v.rw_ex = rwe[0]; v.ld_ex = lde[0]; v.rd_mem = AW'(rdm); v.rw_mem = rwm[0];
    v.ld_mem = ldm[0]; v.acc = acc[0]; v.rdy = rdy[0]; v.rd_wb = AW'(rdw); v.rw_wb = rww[0]; v.exp = e;
    return v;
  endfunction

  // Reference model: counts how many non-wait cycles the in-flight MUL/DIV has spent in EX.
  int md_age = 0;
  int model_stalls = 0;

  function automatic logic [1:0] ref_fwd(int rs, int rdm, int rwm, int ldm, int rdw, int rww);
    if (rs != 0 && rs == rdm && rwm != 0 && ldm == 0) return 2'b01;
    if (rs != 0 && rs == rdw && rww != 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [11:0] ref_out();
    logic [11:0] e;
    bit          wait_c, lu;
    e = '0;
    wait_c = mem_access && !mem_ready;
    lu = load_ex && regwrite_ex && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id);
    e[4:3] = ref_fwd(int'(rs1_ex), int'(rd_mem), int'(regwrite_mem), int'(load_mem), int'(rd_wb), int'(regwrite_wb));
    e[2:1] = ref_fwd(int'(rs2_ex), int'(rd_mem), int'(regwrite_mem), int'(load_mem), int'(rd_wb), int'(regwrite_wb));
    e[0]   = (md_age > 0);
    if (wait_c)                                   e[11:5] = 7'b1111_001;
    else if (md_age > 0) begin
      if (md_age + 1 <= LAT - 1)                  e[11:5] = 7'b1110_010;
    end
    else if (muldiv_ex && LAT >= 2)               e[11:5] = 7'b1110_010;
    else if (lu)                                  e[11:5] = 7'b1100_100;
    return e;
  endfunction

  task automatic model_step();
    if (mem_access && !mem_ready) return;
    if (md_age > 0) md_age = (md_age + 1 >= LAT) ? 0 : md_age + 1;
    else if (muldiv_ex && LAT >= 2) md_age = 1;
  endtask

  vec_t vt[$];

  initial begin
    logic [4:0] seq4 [6];
    logic [4:0] seq5 [7];
    logic [4:0] g;

    idle();
    rst_n = 1'b0;
    muldiv_ex = 1; mem_access = 1; mem_ready = 0;
    rd_mem = 3; regwrite_mem = 1; rs1_ex = 3;
    #2;
    chk("reset_outputs", 32'(dut_v), 32'h0);
`ifdef HAZARD_STALL_CNT_EN
    chk("reset_stall_cnt", stall_cycles, 32'h0);
`endif
    @(negedge clk); idle(); @(negedge clk);
    rst_n = 1'b1;

    vt.push_back(mkv("lu_rs1",    5,0, 0,0, 5,1,1, 0,0,0, 0,1, 0,0, 12'b1100_100_00_00_0));
    vt.push_back(mkv("lu_rs2",    1,7, 0,0, 7,1,1, 0,0,0, 0,1, 0,0, 12'b1100_100_00_00_0));
    vt.push_back(mkv("fwd_mem_wb",0,0, 3,4, 0,0,0, 3,1,0, 0,1, 4,1, 12'b0000_000_01_10_0));
    vt.push_back(mkv("mem_beats", 0,0, 3,0, 0,0,0, 3,1,0, 0,1, 3,1, 12'b0000_000_01_00_0));
    vt.push_back(mkv("x0_fwd",    0,0, 0,0, 0,0,0, 0,1,0, 0,1, 0,1, 12'b0000_000_00_00_0));
    vt.push_back(mkv("x0_lu",     0,0, 0,0, 0,1,1, 0,0,0, 0,1, 0,0, 12'b0000_000_00_00_0));
    vt.push_back(mkv("ld_mem_wb", 0,0, 3,0, 0,0,0, 3,1,1, 0,1, 3,1, 12'b0000_000_10_00_0));
    vt.push_back(mkv("ld_mem_no", 0,0, 6,6, 0,0,0, 6,1,1, 0,1, 0,0, 12'b0000_000_00_00_0));
    vt.push_back(mkv("wait_prio", 5,0, 2,0, 5,1,1, 2,1,0, 1,0, 0,0, 12'b1111_001_01_00_0));
    vt.push_back(mkv("acc_ready", 0,0, 0,9, 0,0,0, 0,0,0, 1,1, 9,1, 12'b0000_000_00_10_0));
    vt.push_back(mkv("lu_norw",   5,0, 0,0, 5,0,1, 0,0,0, 0,1, 0,0, 12'b0000_000_00_00_0));
    vt.push_back(mkv("mem_norw",  0,0, 8,0, 0,0,0, 8,0,0, 0,1, 0,0, 12'b0000_000_00_00_0));
    foreach (vt[i]) begin
      @(negedge clk);
      rs1_id = vt[i].rs1_id; rs2_id = vt[i].rs2_id; rs1_ex = vt[i].rs1_ex; rs2_ex = vt[i].rs2_ex;
      rd_ex = vt[i].rd_ex; regwrite_ex = vt[i].rw_ex; load_ex = vt[i].ld_ex; muldiv_ex = 0;
      rd_mem = vt[i].rd_mem; regwrite_mem = vt[i].rw_mem; load_mem = vt[i].ld_mem;
      mem_access = vt[i].acc; mem_ready = vt[i].rdy; rd_wb = vt[i].rd_wb; regwrite_wb = vt[i].rw_wb;
      #1;
      chk(vt[i].name, 32'(dut_v), 32'(vt[i].exp));
    end

    // lw x5 then dependent op: stall once, then the load result comes from WB
    @(negedge clk); idle();
    rd_ex = 5; regwrite_ex = 1; load_ex = 1; rs1_id = 5; #1;
    chk("lu_seq_stall", 32'(dut_v), 32'(12'b1100_100_00_00_0));
    @(negedge clk); idle();
    rs1_ex = 5; rd_wb = 5; regwrite_wb = 1; #1;
    chk("lu_seq_fwd", 32'(dut_v), 32'(12'b0000_000_10_00_0));

    // {stall_ex, stall_mem, bubble_mem, bubble_wb, busy}; muldiv_ex held high while the op sits in EX
    seq4 = '{5'b10100, 5'b10101, 5'b10101, 5'b00001, 5'b00000, 5'b00000};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); idle();
      muldiv_ex = (c < 4); #1;
      g = {stall_ex, stall_mem, bubble_mem, bubble_wb, muldiv_busy};
      chk($sformatf("mul_c%0d", c), 32'(g), 32'(seq4[c]));
    end

    seq5 = '{5'b10100, 5'b10101, 5'b11011, 5'b11011, 5'b10101, 5'b00001, 5'b00000};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); idle();
      muldiv_ex = (c < 6);
      mem_access = (c == 2 || c == 3); mem_ready = !(c == 2 || c == 3); #1;
      g = {stall_ex, stall_mem, bubble_mem, bubble_wb, muldiv_busy};
      chk($sformatf("mulwait_c%0d", c), 32'(g), 32'(seq5[c]));
    end

    @(negedge clk); idle(); muldiv_ex = 1;
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("rst_mid_mul", 32'(dut_v), 32'h0);
    @(negedge clk); idle(); rst_n = 1'b1; #1;
    chk("after_rst_0", 32'(dut_v), 32'h0);
    @(negedge clk); #1;
    chk("after_rst_1", 32'(dut_v), 32'h0);

    md_age = 0; model_stalls = 0;
    @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [11:0] e;
      @(negedge clk);
      rs1_id = AW'($urandom_range(0, 3)); rs2_id = AW'($urandom_range(0, 3));
      rs1_ex = AW'($urandom_range(0, 3)); rs2_ex = AW'($urandom_range(0, 3));
      rd_ex = AW'($urandom_range(0, 3)); rd_mem = AW'($urandom_range(0, 3)); rd_wb = AW'($urandom_range(0, 3));
      regwrite_ex = 1'($urandom); load_ex = 1'($urandom); muldiv_ex = ($urandom_range(0, 9) == 0);
      regwrite_mem = 1'($urandom); load_mem = 1'($urandom); regwrite_wb = 1'($urandom);
      mem_access = 1'($urandom); mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      e = ref_out();
      chk($sformatf("rand_c%0d", c), 32'(dut_v), 32'(e));
      if (e[11]) model_stalls++;
      model_step();
    end
`ifdef HAZARD_STALL_CNT_EN
    @(negedge clk); idle(); #1;
    chk("stall_cnt", stall_cycles, 32'(model_stalls));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
